// File: rtl/idct_2d_8x8_seq.sv
// idct_2d_8x8_seq
// Sequential 8x8 two-dimensional inverse DCT built around one shared MAC.
// A block of 64 coefficients is loaded in row-major order (index u*8+v,
// u = vertical frequency). A row pass writes 1-D results into the
// intermediate buffer. A column pass writes the pixels back into the
// coefficient buffer. The 64 samples then stream out in raster order.
// All data words are two's complement Q(W-5).4.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    coefficient handshake, in_data = X(u,v)
//   out_valid/out_ready  sample handshake, out_data = x(m,n)
//   out_last             marks sample 63 of a block
//   busy                 block is in ROW, COL or OUT
//   sat                  sticky per block, set if any pass result clamped
module idct_2d_8x8_seq #(
   parameter int DW = 16,
   parameter int IW = 20,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          sat
);

   // Accumulator headroom: 8 products of IW x CW bits cannot overflow.
   localparam int AW = IW + CW + 3;
   localparam logic signed [AW-1:0] RND_HALF = {{(AW-14){1'b0}}, 14'h2000};
   localparam logic signed [AW-1:0] IW_MAX = {{(AW-IW+1){1'b0}}, {(IW-1){1'b1}}};
   localparam logic signed [AW-1:0] IW_MIN = {{(AW-IW+1){1'b1}}, {(IW-1){1'b0}}};
   localparam logic signed [AW-1:0] DW_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] DW_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_ROW  = 2'd1,
      ST_COL  = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   // K[k][n] = round(8192 * a(k) * cos((2n+1)k*pi/16)), Q1.14.
   // The angle index is reduced mod 32 and folded onto one quarter wave.
   function automatic logic signed [CW-1:0] cos_rom(input logic [2:0] k, input logic [2:0] n);
      logic [5:0]           ang_s;
      logic [4:0]           j_s;
      logic [4:0]           m_s;
      logic [4:0]           q_s;
      logic                 neg_s;
      logic [13:0]          mag_s;
      logic signed [CW-1:0] val_s;
      ang_s = {2'b00, n, 1'b1} * {3'b000, k};
      j_s   = ang_s[4:0];
      m_s   = (j_s > 5'd16) ? (5'd0 - j_s) : j_s;
      neg_s = (m_s > 5'd8);
      q_s   = neg_s ? (5'd16 - m_s) : m_s;
      case (q_s)
         5'd0:    mag_s = 14'd8192;
         5'd1:    mag_s = 14'd8035;
         5'd2:    mag_s = 14'd7568;
         5'd3:    mag_s = 14'd6811;
         5'd4:    mag_s = 14'd5793;
         5'd5:    mag_s = 14'd4551;
         5'd6:    mag_s = 14'd3135;
         5'd7:    mag_s = 14'd1598;
         default: mag_s = 14'd0;
      endcase
      if (k == 3'd0) begin
         mag_s = 14'd5793;
         neg_s = 1'b0;
      end
      val_s = {{(CW-14){1'b0}}, mag_s};
      cos_rom = neg_s ? -val_s : val_s;
   endfunction

   function automatic logic signed [IW-1:0] sat_iw(input logic signed [AW-1:0] v);
      if (v > IW_MAX)      sat_iw = IW_MAX[IW-1:0];
      else if (v < IW_MIN) sat_iw = IW_MIN[IW-1:0];
      else                 sat_iw = v[IW-1:0];
   endfunction

   function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
      if (v > DW_MAX)      sat_dw = DW_MAX[DW-1:0];
      else if (v < DW_MIN) sat_dw = DW_MIN[DW-1:0];
      else                 sat_dw = v[DW-1:0];
   endfunction

   state_t                  state_r, state_nxt_s;
   logic signed [DW-1:0]    cbuf_r [64];
   logic signed [IW-1:0]    mbuf_r [64];
   logic [5:0]              cnt_r;
   logic [8:0]              step_r;     // {output index, tap k} in ROW/COL
   logic signed [AW-1:0]    acc_r;
   logic                    in_ready_r, out_valid_r, out_last_r, busy_r, sat_r;
   logic [DW-1:0]           out_data_r;

   logic [2:0]              k_s, pos_s, row_s;
   logic signed [IW-1:0]    opnd_s;
   logic signed [CW-1:0]    coef_s;
   logic signed [IW+CW-1:0] prod_s;
   logic signed [AW-1:0]    sum_s, rnd_s;
   logic                    ovf_iw_s, ovf_dw_s;
   logic signed [IW-1:0]    res_iw_s;
   logic signed [DW-1:0]    res_dw_s;

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_last  = out_last_r;
   assign busy      = busy_r;
   assign sat       = sat_r;

   // MAC datapath: operand select, product, accumulate, round, clamp.
   always_comb begin
      k_s   = step_r[2:0];
      pos_s = step_r[5:3];
      row_s = step_r[8:6];
      if (state_r == ST_ROW) begin
         opnd_s = {{(IW-DW){cbuf_r[{row_s, k_s}][DW-1]}}, cbuf_r[{row_s, k_s}]};
         coef_s = cos_rom(k_s, pos_s);
      end else begin
         opnd_s = mbuf_r[{k_s, pos_s}];
         coef_s = cos_rom(k_s, row_s);
      end
      prod_s = opnd_s * coef_s;
      if (k_s == 3'd0) begin
         sum_s = {{3{prod_s[IW+CW-1]}}, prod_s};
      end else begin
         sum_s = acc_r + {{3{prod_s[IW+CW-1]}}, prod_s};
      end
      rnd_s    = (sum_s + RND_HALF) >>> 14;
      ovf_iw_s = (rnd_s > IW_MAX) || (rnd_s < IW_MIN);
      ovf_dw_s = (rnd_s > DW_MAX) || (rnd_s < DW_MIN);
      res_iw_s = sat_iw(rnd_s);
      res_dw_s = sat_dw(rnd_s);
   end

   // Next-state logic: LOAD -> ROW -> COL -> OUT -> LOAD.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_LOAD: if (in_valid && cnt_r == 6'd63) state_nxt_s = ST_ROW;  else state_nxt_s = ST_LOAD;
         ST_ROW:  if (step_r == 9'd511)           state_nxt_s = ST_COL;  else state_nxt_s = ST_ROW;
         ST_COL:  if (step_r == 9'd511)           state_nxt_s = ST_OUT;  else state_nxt_s = ST_COL;
         ST_OUT:  if (out_ready && out_last_r)    state_nxt_s = ST_LOAD; else state_nxt_s = ST_OUT;
         default: state_nxt_s = ST_LOAD;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_LOAD;
      else        state_r <= state_nxt_s;
   end

   // Word counter, pass step counter and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r  <= 6'd0;
         step_r <= 9'd0;
         acc_r  <= {AW{1'b0}};
      end else begin
         case (state_r)
            ST_LOAD: begin
               step_r <= 9'd0;
               if (in_valid) cnt_r <= cnt_r + 6'd1;
            end
            ST_ROW, ST_COL: begin
               step_r <= step_r + 9'd1;
               acc_r  <= sum_s;
            end
            ST_OUT:  if (out_ready) cnt_r <= cnt_r + 6'd1;
            default: cnt_r <= 6'd0;
         endcase
      end
   end

   // Coefficient / pixel buffer: loaded by the input, overwritten by COL.
   always_ff @(posedge clk) begin
      if (state_r == ST_LOAD && in_valid)        cbuf_r[cnt_r]       <= in_data;
      else if (state_r == ST_COL && k_s == 3'd7) cbuf_r[step_r[8:3]] <= res_dw_s;
   end

   // Intermediate buffer written at the last tap of each row-pass output.
   always_ff @(posedge clk) begin
      if (state_r == ST_ROW && k_s == 3'd7) mbuf_r[step_r[8:3]] <= res_iw_s;
   end

   // Registered handshake, status and output data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         sat_r       <= 1'b0;
         out_data_r  <= {DW{1'b0}};
      end else begin
         in_ready_r <= (state_nxt_s == ST_LOAD);
         busy_r     <= (state_nxt_s != ST_LOAD);
         case (state_r)
            ST_LOAD: if (state_nxt_s == ST_ROW) sat_r <= 1'b0;
            ST_ROW:  if (k_s == 3'd7 && ovf_iw_s) sat_r <= 1'b1;
            ST_COL: begin
               if (k_s == 3'd7 && ovf_dw_s) sat_r <= 1'b1;
               // C[0] was written long before the final column result.
               if (state_nxt_s == ST_OUT) begin
                  out_valid_r <= 1'b1;
                  out_last_r  <= 1'b0;
                  out_data_r  <= cbuf_r[6'd0];
               end
            end
            ST_OUT: begin
               if (out_ready && out_last_r) begin
                  out_valid_r <= 1'b0;
                  out_last_r  <= 1'b0;
               end else if (out_ready) begin
                  out_data_r <= cbuf_r[cnt_r + 6'd1];
                  out_last_r <= (cnt_r == 6'd62);
               end
            end
            default: out_valid_r <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_idct_2d_8x8_seq.sv
// Directed testbench for idct_2d_8x8_seq: zero block, DC block, saturating
// block, forward-DCT round trip, stalls on both handshakes, reset mid-block.
module tb_idct_2d_8x8_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic        busy;
   logic        sat;

   int          checks = 0;
   int          errors = 0;
   int          lat;
   logic [15:0] blk [64];
   logic [15:0] got [64];
   logic [15:0] ref_out [64];
   int          orig [8];

   idct_2d_8x8_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy), .sat(sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_near(input string tag, input int obs, input int expv, input int tol);
      logic ok;
      ok = ((obs - expv) <= tol) && ((expv - obs) <= tol);
      checks++;
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, expv, tol);
      end
   endtask

   task automatic load_block(input int max_gap);
      int g;
      for (int i = 0; i < 64; i++) begin
         if (max_gap > 0) begin
            g = $urandom_range(max_gap, 0);
            in_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
         end
         in_valid = 1'b1;
         in_data  = blk[i];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_data  = 16'h0000;
   endtask

   task automatic collect(input int max_stall, input bit junk, input string tag);
      int          n;
      int          s;
      logic [15:0] hold;
      n = 0;
      if (junk) in_valid = 1'b1;
      while (out_valid !== 1'b1 && n < 3000) begin
         if (junk) in_data = 16'($urandom);
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      lat = n;
      check({tag, " out_valid seen"}, 32'(out_valid), 32'd1);
      for (int i = 0; i < 64; i++) begin
         if (max_stall > 0) begin
            s = $urandom_range(max_stall, 0);
            out_ready = 1'b0;
            for (int j = 0; j < s; j++) begin
               hold = out_data;
               @(posedge clk); #1;
               check({tag, " hold data"}, 32'(out_data), 32'(hold));
               check({tag, " hold valid"}, 32'(out_valid), 32'd1);
            end
         end
         got[i] = out_data;
         check({tag, " out_last"}, 32'(out_last), 32'(i == 63));
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
      check({tag, " valid drops"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
      check({tag, " busy drops"}, 32'(busy), 32'd0);
   endtask

   task automatic fill(input logic [15:0] v);
      for (int i = 0; i < 64; i++) blk[i] = v;
   endtask

   initial begin
      real pi, cm [8][8], acc;
      int  q;
      pi = 3.14159265358979;
      rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst out_last", 32'(out_last), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst sat", 32'(sat), 32'd0);
      check("rst out_data", 32'(out_data), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: all-zero block, latency check
      fill(16'h0000);
      load_block(0);
      check("zero busy", 32'(busy), 32'd1);
      check("zero in_ready", 32'(in_ready), 32'd0);
      collect(0, 1'b0, "zero");
      check("zero latency", 32'(lat), 32'd1024);
      for (int i = 0; i < 64; i++) check("zero sample", 32'(got[i]), 32'd0);
      check("zero sat", 32'(sat), 32'd0);

      // 2: DC only, X(0,0) = 128.0 -> every sample 16.0
      fill(16'h0000);
      blk[0] = 16'h0800;
      load_block(0);
      collect(0, 1'b0, "dc");
      check("dc latency", 32'(lat), 32'd1024);
      for (int i = 0; i < 64; i++) check_near("dc sample", int'($signed(got[i])), 256, 1);
      check("dc sat", 32'(sat), 32'd0);

      // 3: all full-scale positive -> clamp at x(0,0)
      fill(16'h7FFF);
      load_block(0);
      collect(0, 1'b0, "full");
      check("full x00", 32'(got[0]), 32'h7FFF);
      check("full sat", 32'(sat), 32'd1);

      // 4: round trip through a forward DCT of a row-constant block
      orig[0] = 16; orig[1] = 20; orig[2] = 15; orig[3] = 30;
      orig[4] = 12; orig[5] = 13; orig[6] = 12; orig[7] = 13;
      for (int k = 0; k < 8; k++)
         for (int n = 0; n < 8; n++)
            cm[k][n] = 0.5 * ((k == 0) ? 1.0 / $sqrt(2.0) : 1.0) * $cos(real'((2 * n + 1) * k) * pi / 16.0);
      for (int u = 0; u < 8; u++)
         for (int v = 0; v < 8; v++) begin
            acc = 0.0;
            for (int m = 0; m < 8; m++)
               for (int n = 0; n < 8; n++)
                  acc = acc + cm[u][m] * cm[v][n] * real'(orig[m]);
            q = $rtoi($floor(acc * 16.0 + 0.5));
            blk[u * 8 + v] = 16'(q);
         end
      load_block(0);
      check("rt sat cleared", 32'(sat), 32'd0);
      collect(0, 1'b0, "rt");
      for (int i = 0; i < 64; i++) begin
         check_near("rt sample", int'($signed(got[i])), orig[i / 8] * 16, 2);
         ref_out[i] = got[i];
      end
      check("rt sat", 32'(sat), 32'd0);

      // 5: same block with input gaps, output stalls and ignored in_valid
      load_block(3);
      collect(5, 1'b1, "stall");
      for (int i = 0; i < 64; i++) check("stall sample", 32'(got[i]), 32'(ref_out[i]));

      // 6: reset during COL, then a fresh block
      fill(16'h7FFF);
      load_block(0);
      repeat (600) begin @(posedge clk); #1; end
      check("abort busy", 32'(busy), 32'd1);
      check("abort sat pre", 32'(sat), 32'd1);
      #1 rst_n = 1'b0;
      #2;
      check("abort in_ready", 32'(in_ready), 32'd1);
      check("abort busy rst", 32'(busy), 32'd0);
      check("abort sat rst", 32'(sat), 32'd0);
      check("abort out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      fill(16'h0000);
      blk[0] = 16'h0800;
      load_block(0);
      collect(0, 1'b0, "post");
      check("post latency", 32'(lat), 32'd1024);
      for (int i = 0; i < 64; i++) check_near("post sample", int'($signed(got[i])), 256, 1);
      check("post sat", 32'(sat), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
